mul_q824_iter: RTL and testbench

- Sequential signed Q8.24 fixed-point multiplier; the arithmetic inverse companion to the Q8.24 divider.
- Uses a radix-2 shift-add datapath over operand magnitudes, then applies sign correction, optional rounding and saturation.
- Input and output use valid/ready handshakes, so it can be placed in the Heston pricing datapath between pipelined stages.
- Bit-exact against a software reference of (a*b)/2^24.

---
 rtl/q824_pkg.sv | 20 ++
 rtl/mul_q824_iter_if.sv | 23 ++
 rtl/q824_sat_neg.sv | 52 +++++
 rtl/mul_q824_iter.sv | 102 ++++++++++
 tb/tb_mul_q824_iter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/q824_pkg.sv
// Shared Q8.24 fixed-point definitions for the multiplier and divider datapaths.
package q824_pkg;

    localparam int Q824_WIDTH = 32;
    localparam int Q824_FRAC  = 24;

    localparam logic [31:0] Q824_ONE = 32'h0100_0000;
    localparam logic [31:0] Q824_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q824_MIN = 32'h8000_0000;

    typedef logic signed [Q824_WIDTH-1:0] q824_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } q824_state_e;

endpackage

// File: rtl/mul_q824_iter_if.sv
// Valid/ready operand and result bus for the iterative Q8.24 multiplier.
interface mul_q824_iter_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] p;
    logic                    ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, ovf
    );
endinterface

// File: rtl/q824_sat_neg.sv
// Sign-apply, optional rounding and saturation of a 2*WIDTH magnitude product.
// MUL_Q824_ROUND_EN: when defined, rounds half away from zero before the shift;
// otherwise the magnitude is truncated (toward zero).
module q824_sat_neg #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic [2*WIDTH-1:0]      mag,
    input  logic                    neg,
    output logic signed [WIDTH-1:0] p,
    output logic                    ovf
);

`ifdef MUL_Q824_ROUND_EN
    localparam logic [2*WIDTH-1:0] RND = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FRAC-1);
`else
    localparam logic [2*WIDTH-1:0] RND = '0;
`endif

    // Largest magnitude representable on the negative side is 2^(WIDTH-1).
    localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] POS_LIM = NEG_LIM - 1'b1;

    function automatic logic [2*WIDTH-1:0] round_mag(input logic [2*WIDTH-1:0] m);
        logic [2*WIDTH-1:0] s;
        s = m + RND;
        return s >> FRAC;
    endfunction

    // Returns {ovf, result}; a zero magnitude yields +0 whatever the sign.
    function automatic logic [WIDTH:0] saturate(input logic [2*WIDTH-1:0] m, input logic n);
        logic [2*WIDTH-1:0] nm;
        nm = '0 - m;
        if (n) begin
            if (m > NEG_LIM) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
            else             return {1'b0, nm[WIDTH-1:0]};
        end else begin
            if (m > POS_LIM) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
            else             return {1'b0, m[WIDTH-1:0]};
        end
    endfunction

    logic [WIDTH:0] res;

    // Round, shift, sign and clamp in one combinational step.
    always_comb begin
        res = saturate(round_mag(mag), neg);
        p   = res[WIDTH-1:0];
        ovf = res[WIDTH];
    end

endmodule

// File: rtl/mul_q824_iter.sv
// Iterative signed Q8.24 multiplier: radix-2 shift-add over operand magnitudes,
// then sign/round/saturate. Accept-to-out_valid latency is 34 cycles.
// MUL_Q824_ROUND_EN selects round-half-away-from-zero (see q824_sat_neg).
module mul_q824_iter
    import q824_pkg::*;
#(
    parameter int WIDTH = Q824_WIDTH,
    parameter int FRAC  = Q824_FRAC
) (
    input logic            clk,
    input logic            rst,
    mul_q824_iter_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

    q824_state_e             state;
    logic [CW-1:0]           cnt;
    logic                    fin_ph;
    logic [2*WIDTH-1:0]      mcand;
    logic [WIDTH-1:0]        mplier;
    logic [2*WIDTH-1:0]      acc;
    logic                    sign;
    logic signed [WIDTH-1:0] p_r;
    logic                    ovf_r;
    logic signed [WIDTH-1:0] sat_p;
    logic                    sat_ovf;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = $unsigned(v);
        return v[WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    q824_sat_neg #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_sat (
        .mag (acc),
        .neg (sign),
        .p   (sat_p),
        .ovf (sat_ovf)
    );

    // Control FSM plus shift-add iteration; FINAL spans two cycles so the
    // wide add/saturate path gets a full cycle before the result is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            fin_ph <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            p_r    <= '0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, magnitude(bus.a)};
                        mplier <= magnitude(bus.b);
                        acc    <= '0;
                        sign   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FINAL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINAL: begin
                    p_r    <= sat_p;
                    ovf_r  <= sat_ovf;
                    fin_ph <= ~fin_ph;
                    if (fin_ph) state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.p         = p_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mul_q824_iter.sv
// Scoreboard bench for mul_q824_iter: expectations queued at issue, checked at output.
module tb_mul_q824_iter;

    typedef struct {
        logic [31:0] p;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mul_q824_iter_if #(.WIDTH(32)) bus ();

    mul_q824_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Independent reference: exact 64-bit product, magnitude round/truncate, clamp.
    function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
        exp_t   e;
        longint pr, mag, m;
        bit     neg;
        pr  = longint'(a) * longint'(b);
        neg = pr < 0;
        mag = neg ? -pr : pr;
`ifdef MUL_Q824_ROUND_EN
        mag = mag + 64'd8388608;
`endif
        m = mag >>> 24;
        if (!neg) begin
            if (m > 64'h7FFF_FFFF) begin e.p = 32'h7FFF_FFFF; e.ovf = 1'b1; end
            else begin e.p = m[31:0]; e.ovf = 1'b0; end
        end else begin
            if (m > 64'h8000_0000) begin e.p = 32'h8000_0000; e.ovf = 1'b1; end
            else begin e.p = 32'(-m); e.ovf = 1'b0; end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ep, input logic eovf);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL issue_wait: in_ready got 0 after 100 cycles, required 1");
        end
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        e.p = ep; e.ovf = eovf;
        sb.push_back(e);
    endtask

    // Waits for a result, checks latency and busy in_ready, compares against the
    // scoreboard; with hold>0 out_ready is kept low that many cycles first.
    task automatic collect(input string name, input int hold);
        int   n;
        bit   rdy_seen;
        exp_t e;
        logic [31:0] p0;
        logic        o0;
        n = 0; rdy_seen = 0;
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready) rdy_seen = 1;
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (!bus.out_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid got 0 after 200 cycles, required 1", name);
            return;
        end
        n_cmp++;
        if (cyc - acc_cyc !== 34) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required 34", name, cyc - acc_cyc);
        end
        n_cmp++;
        if (rdy_seen) begin
            n_fail++;
            $display("FAIL %s_busy_ready: in_ready got 1 while busy, required 0", name);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: got result p=%h with empty queue, required none", name, bus.p);
            return;
        end
        e = sb.pop_front();
        if (bus.p !== e.p || bus.ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL %s: got p=%h ovf=%b, required p=%h ovf=%b", name, bus.p, bus.ovf, e.p, e.ovf);
        end
        p0 = bus.p; o0 = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.p !== p0 || bus.ovf !== o0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold%0d: got v=%b p=%h ovf=%b rdy=%b, required v=1 p=%h ovf=%b rdy=0",
                         name, i, bus.out_valid, bus.p, bus.ovf, bus.in_ready, p0, o0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: got out_valid=%b in_ready=%b, required 0 and 1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.p !== 32'h0 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b p=%h ovf=%b, required rdy=1 v=0 p=0 ovf=0",
                     bus.in_ready, bus.out_valid, bus.p, bus.ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        issue(32'h0100_0000, 32'h0200_0000, 32'h0200_0000, 1'b0); collect("one_x_two", 0);
        issue(32'h0180_0000, 32'hFE00_0000, 32'hFD00_0000, 1'b0); collect("onehalf_x_negtwo", 0);
        issue(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0); collect("zero_a", 0);
        issue(32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0); collect("zero_b", 0);
        issue(32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b0); collect("min_x_one", 0);
    endtask

    task automatic test_saturation();
        issue(32'h6400_0000, 32'h0200_0000, 32'h7FFF_FFFF, 1'b1); collect("sat_pos", 0);
        issue(32'h8000_0000, 32'hFF00_0000, 32'h7FFF_FFFF, 1'b1); collect("sat_min_x_negone", 0);
        issue(32'h6400_0000, 32'hFE00_0000, 32'h8000_0000, 1'b1); collect("sat_neg", 0);
    endtask

    task automatic test_rounding();
`ifdef MUL_Q824_ROUND_EN
        issue(32'h0000_0001, 32'h0080_0000, 32'h0000_0001, 1'b0); collect("round_half", 0);
        issue(32'hFFFF_FFFF, 32'h0080_0000, 32'hFFFF_FFFF, 1'b0); collect("round_half_neg", 0);
`else
        issue(32'h0000_0001, 32'h0080_0000, 32'h0000_0000, 1'b0); collect("trunc_half", 0);
        issue(32'hFFFF_FFFF, 32'h0080_0000, 32'h0000_0000, 1'b0); collect("trunc_half_neg", 0);
`endif
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(32'h0300_0000, 32'hFF80_0000, 32'hFE80_0000, 1'b0);
        collect("backpressure", 5);
    endtask

    task automatic test_reset_midop();
        int n;
        bit seen;
        issue(32'h0500_0000, 32'h0300_0000, 32'h0F00_0000, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_reset: got out_valid=%b in_ready=%b, required 0 and 1",
                     bus.out_valid, bus.in_ready);
        end
        seen = 0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL midop_discard: out_valid got 1 after reset, required 0");
        end
        issue(32'h0040_0000, 32'h0040_0000, 32'h0010_0000, 1'b0); collect("quarter_sq", 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) a = {{8{a[31]}}, a[23:0]};
            if (i % 3 == 2) b = {{10{b[31]}}, b[21:0]};
            e = model(a, b);
            issue(a, b, e.p, e.ovf);
            collect($sformatf("b2b_%0d", i), 0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
